// File: rtl/bf_jump_table_builder_if.sv
// Program-read, jump-table-write and status signals between the bracket
// pre-scan block (master) and the memories/core controller (slave).
interface bf_jump_table_builder_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] ix_addr;
    logic [7:0]        ix_data;
    logic              jt_we;
    logic [ADDR_W-1:0] jt_addr;
    logic [ADDR_W-1:0] jt_data;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W-1:0] pair_count;

    modport master (
        input  start, ix_data,
        output ix_addr, jt_we, jt_addr, jt_data, busy, done, err, pair_count
    );

    modport slave (
        output start, ix_data,
        input  ix_addr, jt_we, jt_addr, jt_data, busy, done, err, pair_count
    );
endinterface

// File: rtl/bf_jump_table_builder.sv
// Scans program memory, matches [ ] with a stack and writes both jump targets per pair.
// start->done latency 2(N+1)+2P clocks; no backpressure, table writes are single-cycle strobes.
module bf_jump_table_builder #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 32,
    parameter int SP_W   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    bf_jump_table_builder_if.master       bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CHECK, S_WR_OPEN, S_WR_CLOSE, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] o_q, o_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] ix_addr_q, ix_addr_d;
    logic              jt_we_q, jt_we_d;
    logic [ADDR_W-1:0] jt_addr_q, jt_addr_d;
    logic [ADDR_W-1:0] jt_data_q, jt_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W-1:0] pair_count_q, pair_count_d;

    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic              push;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              adv;
    logic              fin;
    logic [SP_W-1:0]   fin_sp;

    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = IDX_W'(sp_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        c_d          = c_q;
        o_d          = o_q;
        sp_d         = sp_q;
        ix_addr_d    = ix_addr_q;
        jt_we_d      = 1'b0;
        jt_addr_d    = jt_addr_q;
        jt_data_d    = jt_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        pair_count_d = pair_count_q;
        push         = 1'b0;
        adv          = 1'b0;
        fin          = 1'b0;
        fin_sp       = sp_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    a_d          = '0;
                    ix_addr_d    = '0;
                    sp_d         = '0;
                    done_d       = 1'b0;
                    err_d        = 2'd0;
                    pair_count_d = '0;
                    busy_d       = 1'b1;
                    state_d      = S_READ;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                case (bus.ix_data)
                    8'h00: fin = 1'b1;
                    8'h5B: begin
                        if (sp_q == SP_W'(DEPTH)) begin
                            err_d   = 2'd2;
                            busy_d  = 1'b0;
                            state_d = S_ERROR;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + 1'b1;
                            adv  = 1'b1;
                        end
                    end
                    8'h5D: begin
                        if (sp_q == '0) begin
                            err_d   = 2'd1;
                            busy_d  = 1'b0;
                            state_d = S_ERROR;
                        end else begin
                            sp_d      = sp_q - 1'b1;
                            o_d       = stack_q[pop_idx];
                            c_d       = a_q;
                            jt_we_d   = 1'b1;
                            jt_addr_d = stack_q[pop_idx];
                            jt_data_d = a_q;
                            state_d   = S_WR_OPEN;
                        end
                    end
                    default: adv = 1'b1;
                endcase
            end
            S_WR_OPEN: begin
                jt_we_d      = 1'b1;
                jt_addr_d    = c_q;
                jt_data_d    = o_q;
                pair_count_d = pair_count_q + 1'b1;
                state_d      = S_WR_CLOSE;
            end
            S_WR_CLOSE: adv = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // The last address ends the scan as if a terminator followed it.
        if (adv) begin
            if (a_q == {ADDR_W{1'b1}}) begin
                fin    = 1'b1;
                fin_sp = sp_d;
            end else begin
                a_d       = a_q + 1'b1;
                ix_addr_d = a_q + 1'b1;
                state_d   = S_READ;
            end
        end

        if (fin) begin
            busy_d = 1'b0;
            if (fin_sp == '0) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                err_d   = 2'd3;
                state_d = S_ERROR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            c_q          <= '0;
            o_q          <= '0;
            sp_q         <= '0;
            ix_addr_q    <= '0;
            jt_we_q      <= 1'b0;
            jt_addr_q    <= '0;
            jt_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 2'd0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            c_q          <= c_d;
            o_q          <= o_d;
            sp_q         <= sp_d;
            ix_addr_q    <= ix_addr_d;
            jt_we_q      <= jt_we_d;
            jt_addr_q    <= jt_addr_d;
            jt_data_q    <= jt_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pair_count_q <= pair_count_d;
        end
    end

    // Stack contents need no reset: sp bounds which entries are live.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= a_q;
    end

    assign bus.ix_addr    = ix_addr_q;
    assign bus.jt_we      = jt_we_q;
    assign bus.jt_addr    = jt_addr_q;
    assign bus.jt_data    = jt_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.pair_count = pair_count_q;
endmodule

// File: tb/tb_bf_jump_table_builder.sv
// Bench for the bracket pre-scan: program memory model, stack-based reference, write scoreboard.
module tb_bf_jump_table_builder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int SP_W   = 3;
    localparam int MEM_N  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bf_jump_table_builder_if #(.ADDR_W(ADDR_W)) bus();

    bf_jump_table_builder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [MEM_N];
    logic [7:0] mem_q;
    always @(posedge clk) mem_q <= mem[bus.ix_addr];
    assign bus.ix_data = mem_q;

    int errors = 0;
    int checks = 0;

    int exp_wa[$];
    int exp_wd[$];
    int m_err, m_pairs, m_lat;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the program with a queue as the bracket stack.
    function automatic void model();
        int stk[$];
        int visited = 0;
        int o;
        m_err = 0;
        m_pairs = 0;
        exp_wa.delete();
        exp_wd.delete();
        for (int a = 0; a < MEM_N; a++) begin
            visited++;
            if (mem[a] == 8'h00) begin
                m_err = (stk.size() != 0) ? 3 : 0;
                break;
            end
            if (mem[a] == 8'h5B) begin
                if (stk.size() == DEPTH) begin m_err = 2; break; end
                stk.push_back(a);
            end else if (mem[a] == 8'h5D) begin
                if (stk.size() == 0) begin m_err = 1; break; end
                o = stk.pop_back();
                exp_wa.push_back(o); exp_wd.push_back(a);
                exp_wa.push_back(a); exp_wd.push_back(o);
                m_pairs++;
            end
            if (a == MEM_N - 1) m_err = (stk.size() != 0) ? 3 : 0;
        end
        m_lat = 2 * visited + 2 * m_pairs;
    endfunction

    // Every table write must be the next one the reference expects.
    always @(negedge clk) begin
        if (!rst && bus.jt_we) begin
            if (exp_wa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none",
                         bus.jt_addr, bus.jt_data);
            end else begin
                chk("jt_addr", int'(bus.jt_addr), exp_wa.pop_front());
                chk("jt_data", int'(bus.jt_data), exp_wd.pop_front());
            end
        end
    end

    task automatic load(input string s, input bit term);
        for (int i = 0; i < MEM_N; i++) mem[i] = 8'h2E;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
        if (term) mem[s.len()] = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " ix_addr"}, int'(bus.ix_addr), 0);
        chk({tag, " jt_we"}, int'(bus.jt_we), 0);
        chk({tag, " jt_addr"}, int'(bus.jt_addr), 0);
        chk({tag, " jt_data"}, int'(bus.jt_data), 0);
        chk({tag, " busy"}, int'(bus.busy), 0);
        chk({tag, " done"}, int'(bus.done), 0);
        chk({tag, " err"}, int'(bus.err), 0);
        chk({tag, " pair_count"}, int'(bus.pair_count), 0);
    endtask

    task automatic run_scan(input string name, input int lit_lat, input int lit_err,
                            input int lit_pairs);
        int  edges;
        bit  busy_ok;
        model();
        if (lit_lat >= 0) begin
            chk({name, " model_lat"}, m_lat, lit_lat);
            chk({name, " model_err"}, m_err, lit_err);
            chk({name, " model_pairs"}, m_pairs, lit_pairs);
        end
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        edges = 0;
        busy_ok = 1'b1;
        while (!(bus.done || bus.err != 2'd0) && edges < 3000) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        chk({name, " busy_during_scan"}, int'(busy_ok), 1);
        chk({name, " latency"}, edges, m_lat);
        chk({name, " err"}, int'(bus.err), m_err);
        chk({name, " done"}, int'(bus.done), (m_err == 0) ? 1 : 0);
        chk({name, " busy_end"}, int'(bus.busy), 0);
        chk({name, " pair_count"}, int'(bus.pair_count), m_pairs);
        repeat (3) @(negedge clk);
        chk({name, " writes_left"}, exp_wa.size(), 0);
        chk({name, " sticky_status"}, int'({bus.done, bus.err}),
            int'({(m_err == 0), 2'(m_err)}));
    endtask

    initial begin
        int len, depth, r;
        bit ok;
        string s;
        bus.start = 1'b0;
        load("", 1'b1);
        #12;
        check_reset_vals("reset");
        @(negedge clk); rst = 1'b0;

        load("[-]", 1'b1);
        run_scan("simple_pair", 10, 0, 1);

        load("[[]]", 1'b1);
        model();
        chk("nest_order0", exp_wa[0] * 16 + exp_wd[0], 1 * 16 + 2);
        chk("nest_order1", exp_wa[1] * 16 + exp_wd[1], 2 * 16 + 1);
        chk("nest_order2", exp_wa[2] * 16 + exp_wd[2], 0 * 16 + 3);
        chk("nest_order3", exp_wa[3] * 16 + exp_wd[3], 3 * 16 + 0);
        run_scan("nested", 14, 0, 2);

        load("]", 1'b1);
        run_scan("unmatched_close", 2, 1, 0);

        load("[[[[[", 1'b0);
        run_scan("overflow", 10, 2, 0);

        load("[[]", 1'b1);
        run_scan("unclosed", 10, 3, 1);

        // Reset while the first WR_OPEN write is on the bus.
        load("[[]]", 1'b1);
        model();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        len = 0;
        while (!bus.jt_we && len < 100) begin @(negedge clk); len++; end
        chk("reach_wr_open", int'(bus.jt_we), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk); rst = 1'b0;
        run_scan("after_reset", 14, 0, 2);

        s = "";
        for (int i = 0; i < MEM_N / 2; i++) s = {s, "[]"};
        load(s, 1'b0);
        run_scan("full_range_pairs", 768, 0, 128);

        load("[", 1'b0);
        run_scan("full_range_unclosed", 512, 3, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < MEM_N; i++) mem[i] = 8'h2E;
            len = $urandom_range(1, 16);
            depth = 0;
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (n % 2 == 1) begin
                    mem[i] = (r < 4) ? 8'h5B : (r < 8) ? 8'h5D : 8'h41;
                end else begin
                    if ((depth == 0 || r < 4) && depth < DEPTH) begin
                        mem[i] = 8'h5B; depth++;
                    end else if (r < 8 && depth > 0) begin
                        mem[i] = 8'h5D; depth--;
                    end else begin
                        mem[i] = 8'h2D;
                    end
                end
            end
            for (int i = 0; i < depth && n % 2 == 0; i++) mem[len + i] = 8'h5D;
            mem[len + ((n % 2 == 0) ? depth : 0)] = 8'h00;
            run_scan($sformatf("random%0d", n), -1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
